// File: rtl/uart_pkg.sv
// Shared UART constants used as parameter defaults across the receive path.
package uart_pkg;

    // Byte width produced by the UART receiver.
    localparam int unsigned UART_DATA_W = 8;

    // Default receive FIFO depth (power of two).
    localparam int unsigned UART_RX_FIFO_DEPTH = 16;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with extended-pointer full/empty detection.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W = UART_DATA_W,
    parameter int unsigned DEPTH  = UART_RX_FIFO_DEPTH,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W:0]   level,
    output logic              full,
    output logic              empty
);

    localparam int unsigned PTR_W = ADDR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_wr;
    logic              do_rd;

    // A pop frees the slot, so a write while full is accepted if it coincides with a read.
    always_comb begin
        do_rd = rd_en & ~empty;
        do_wr = wr_en & (~full | do_rd);
    end

    // Pointer update; MSB separates the full and empty cases when low bits match.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Storage array; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[ADDR_W-1:0]];
    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == PTR_W'(DEPTH));
    assign empty   = (wr_ptr == rd_ptr);

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: edge-detects rx_done, queues bytes,
// exposes a valid/ready read port and a sticky overflow flag for dropped bytes.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W = UART_DATA_W,
    parameter int unsigned DEPTH  = UART_RX_FIFO_DEPTH,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_done,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [ADDR_W:0]   level,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    input  logic              ovf_clear
);

    logic done_q;
    logic wr_evt;
    logic rd_evt;
    logic drop;

    // Write on rx_done rising edge only; a read in the same cycle makes room when full.
    always_comb begin
        wr_evt = rx_done & ~done_q;
        rd_evt = rd_ready & ~empty;
        drop   = wr_evt & full & ~rd_evt;
    end

    // done_q resets high so an rx_done held through reset release is not captured.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) done_q <= 1'b1;
        else       done_q <= rx_done;
    end

    // Sticky overflow; a drop in the same cycle as a clear leaves it set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          overflow <= 1'b0;
        else if (drop)      overflow <= 1'b1;
        else if (ovf_clear) overflow <= 1'b0;
    end

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_evt),
        .wr_data (rx_data),
        .rd_en   (rd_evt),
        .rd_data (rd_data),
        .level   (level),
        .full    (full),
        .empty   (empty)
    );

    assign rd_valid = ~empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with a byte scoreboard queue.
module tb_uart_rx_fifo;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] rx_data;
    logic          rx_done;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [AW:0]   level;
    logic          full;
    logic          empty;
    logic          overflow;
    logic          ovf_clear;

    int n_compared   = 0;
    int n_mismatched = 0;
    logic [DW-1:0] sb [$];

    uart_rx_fifo #(
        .DATA_W (DW),
        .DEPTH  (DEPTH),
        .ADDR_W (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .level     (level),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .ovf_clear (ovf_clear)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One-cycle rx_done pulse followed by a low cycle; model accepts only if not full.
    task automatic pulse_write(input logic [DW-1:0] b);
        rx_data = b;
        rx_done = 1'b1;
        if (sb.size() < DEPTH) sb.push_back(b);
        step();
        rx_done = 1'b0;
        step();
    endtask

    // Pop one entry, comparing against the scoreboard head.
    task automatic pop(input string tag);
        logic [DW-1:0] exp;
        check({tag, "_valid"}, 32'(rd_valid), 32'd1);
        if (sb.size() == 0) begin
            n_compared++;
            n_mismatched++;
            $error("FAIL %s_sb: observed pop expected no entry", tag);
        end else begin
            exp = sb.pop_front();
            check({tag, "_data"}, 32'(rd_data), 32'(exp));
        end
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        rx_data   = '0;
        rx_done   = 1'b0;
        rd_ready  = 1'b0;
        ovf_clear = 1'b0;
        step();
        step();
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        reset = 1'b0;
        step();

        // Single pulse: visible right after the capturing edge.
        rx_data = 8'hA5;
        rx_done = 1'b1;
        sb.push_back(8'hA5);
        step();
        rx_done = 1'b0;
        check("t1_valid", 32'(rd_valid), 32'd1);
        check("t1_data", 32'(rd_data), 32'hA5);
        check("t1_level", 32'(level), 32'd1);
        step();
        pop("t1_pop");
        check("t1_empty", 32'(empty), 32'd1);
        check("t1_level0", 32'(level), 32'd0);

        // Long rx_done yields one entry.
        rx_data = 8'h3C;
        rx_done = 1'b1;
        sb.push_back(8'h3C);
        repeat (10) step();
        rx_done = 1'b0;
        step();
        check("t2_level1", 32'(level), 32'd1);
        pulse_write(8'h3D);
        check("t2_level2", 32'(level), 32'd2);
        pop("t2_pop0");
        pop("t2_pop1");
        check("t2_empty", 32'(empty), 32'd1);

        // Fill, overflow drop, drain.
        for (int i = 0; i < 16; i++) pulse_write(8'(i));
        check("t3_full", 32'(full), 32'd1);
        check("t3_level", 32'(level), 32'd16);
        check("t3_ovf0", 32'(overflow), 32'd0);
        pulse_write(8'hFF);
        check("t3_ovf1", 32'(overflow), 32'd1);
        check("t3_level_drop", 32'(level), 32'd16);
        for (int i = 0; i < 16; i++) pop("t3_pop");
        check("t3_empty", 32'(empty), 32'd1);
        ovf_clear = 1'b1;
        step();
        ovf_clear = 1'b0;
        check("t3_ovf_clr", 32'(overflow), 32'd0);

        // Write concurrent with read while full.
        for (int i = 16; i < 32; i++) pulse_write(8'(i));
        check("t4_full", 32'(full), 32'd1);
        rx_data  = 8'h55;
        rx_done  = 1'b1;
        rd_ready = 1'b1;
        check("t4_head", 32'(rd_data), 32'(sb.pop_front()));
        sb.push_back(8'h55);
        step();
        rx_done  = 1'b0;
        rd_ready = 1'b0;
        check("t4_level", 32'(level), 32'd16);
        check("t4_ovf", 32'(overflow), 32'd0);
        step();

        // Drop and clear together: set wins.
        pulse_write(8'hEE);
        check("t5_ovf_set", 32'(overflow), 32'd1);
        rx_data   = 8'hDD;
        rx_done   = 1'b1;
        ovf_clear = 1'b1;
        step();
        rx_done   = 1'b0;
        ovf_clear = 1'b0;
        check("t5_set_wins", 32'(overflow), 32'd1);
        check("t5_level", 32'(level), 32'd16);
        ovf_clear = 1'b1;
        step();
        ovf_clear = 1'b0;
        check("t5_cleared", 32'(overflow), 32'd0);
        for (int i = 0; i < 16; i++) pop("t4_pop");
        check("t4_empty", 32'(empty), 32'd1);

        // Reset mid-operation with rx_done held high across release.
        for (int i = 0; i < 5; i++) pulse_write(8'(8'h60 + i));
        check("t6_level5", 32'(level), 32'd5);
        rx_data = 8'h77;
        rx_done = 1'b1;
        reset   = 1'b1;
        #1;
        check("t6_async_level", 32'(level), 32'd0);
        check("t6_async_valid", 32'(rd_valid), 32'd0);
        sb.delete();
        step();
        reset = 1'b0;
        repeat (3) step();
        check("t6_level", 32'(level), 32'd0);
        check("t6_valid", 32'(rd_valid), 32'd0);
        rx_done = 1'b0;
        step();
        pulse_write(8'h99);
        check("t6_level1", 32'(level), 32'd1);
        pop("t6_pop");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer directly downstream of the UART receiver. It captures each byte the receiver completes (byte bus plus completion flag) into a first-word-fall-through FIFO, and hands bytes to the consumer over a valid/ready handshake. It also reports fill level and flags bytes dropped on overflow with a sticky flag.

## Interface
Parameters:
- DATA_W, 8, byte width; matches receiver output.
- DEPTH, 16, FIFO entries; power of two, ≥2.
- ADDR_W, 4, log2(DEPTH).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- rx_data  in  DATA_W  byte from receiver; valid when rx_done is high.
- rx_done  in  1  receiver completion flag; level, may stay high for many cycles.
- rd_data  out  DATA_W  head-of-FIFO byte; valid when rd_valid is high.
- rd_valid  out  1  FIFO non-empty.
- rd_ready  in  1  consumer accepts rd_data this cycle.
- level  out  ADDR_W+1  current entry count, 0..DEPTH.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- overflow  out  1  sticky; set when a byte is dropped.
- ovf_clear  in  1  synchronous clear of overflow.

## Operation
- Write event: rising edge of rx_done, i.e. rx_done=1 and done_q=0, where done_q is rx_done registered.
  - One byte per rising edge, however long rx_done stays high.
  - rx_data is sampled in the same cycle as the write event.
- Read event: rd_valid & rd_ready. Pops the head entry.
- Storage: DEPTH×DATA_W register array.
  - wr_ptr and rd_ptr are ADDR_W+1 bits; the low ADDR_W bits index the array, and the MSB distinguishes full from empty.
  - Pointers wrap naturally modulo 2·DEPTH.
  - level = wr_ptr − rd_ptr (ADDR_W+1-bit unsigned subtraction).
- rd_data = mem[rd_ptr[ADDR_W-1:0]] (first-word-fall-through). It is undefined-but-stable when empty; the bench must not check it when rd_valid=0.
- Write while full:
  - If a read happens in the same cycle, the write is accepted and level stays DEPTH.
  - Otherwise the byte is dropped, the pointers do not move, and overflow is set.
- Write and read in the same cycle when not empty and not full: both happen; level is unchanged.
- Write while empty with rd_ready=1: the write happens and no read occurs, because rd_valid=0.
- overflow:
  - Cleared by ovf_clear.
  - If a drop and ovf_clear occur in the same cycle, overflow ends set (set wins).
- Read when empty: ignored; rd_ptr does not move.

## Timing
- Reset values:
  - rd_valid=0, empty=1, full=0, level=0, overflow=0, both pointers=0.
  - done_q=1, so an rx_done already high while reset is asserted or on release is not captured.
  - Array contents are not reset.
- Write latency: write event at clock edge N, then rd_valid=1, level updated, and rd_data=byte all visible after edge N (cycle N+1).
- Read: pop at edge N; the next entry or rd_valid=0 is visible after edge N.
- full, empty and level are all derived from registered pointers and are consistent in every cycle.
- Reset asserted mid-operation: the FIFO empties immediately (asynchronously) and any in-flight write is lost.
- Throughput: one write per rx_done rising edge plus one read per cycle. The receiver rate is far below the clock rate, so the write side never limits throughput.

## Structure
- The shared package uart_pkg holds UART_DATA_W=8 and the default depth constant UART_RX_FIFO_DEPTH=16. This block uses both as parameter defaults.
- One sub-module, sync_fifo:
  - Parameterised DATA_W/DEPTH/ADDR_W.
  - Ports: wr_en/wr_data/rd_en/rd_data/level/full/empty.
- uart_rx_fifo wraps sync_fifo and adds the rx_done edge detector, the handshake mapping and the overflow logic.

## Test plan
- Reset, then a pulse on rx_done with rx_data=0xA5 → next cycle rd_valid=1, rd_data=0xA5, level=1. With rd_ready=1 for one cycle → empty=1, level=0.
- Hold rx_done high for 10 cycles with rx_data=0x3C → exactly one entry (level=1). A second rising edge with 0x3D → level=2, and reads return 0x3C then 0x3D.
- Write 16 bytes 0x00..0x0F without reading → full=1, level=16. A 17th write of 0xFF → dropped, overflow=1, level=16. Read all 16 → 0x00..0x0F in order, with no 0xFF.
- While full, a write of 0x55 in the same cycle as a read → level stays 16, overflow stays 0, and 0x55 emerges after the 15 remaining older bytes.
- overflow=1 with ovf_clear pulsed while a drop occurs in the same cycle → overflow stays 1. ovf_clear alone on the next cycle → overflow=0.
- Assert reset with level=5 and rx_done high; release it with rx_done still high → level=0, rd_valid=0, no entry captured until rx_done falls and rises again.
